// File: rtl/bf_exec_core.sv
// Brainfuck execution core.
// Fetches opcodes from a synchronous program RAM and executes them against a
// synchronous data RAM. It handles forward skip on '[', a bounded loop stack,
// valid/ready stdout and stdin, and sticky halt and error reporting.
module bf_exec_core #(
  parameter int PROG_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int CELL_WIDTH      = 8,
  parameter int STACK_DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic [7:0]                 prog_rdata,
  output logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [CELL_WIDTH-1:0]      data_rdata,
  output logic                       data_wen,
  output logic [CELL_WIDTH-1:0]      data_wdata,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       halted,
  output logic                       error,
  output logic [1:0]                 err_code
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int DEP_W = PROG_ADDR_WIDTH + 1;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_LB    = 8'h5B;
  localparam logic [7:0] OP_RB    = 8'h5D;
  localparam logic [7:0] OP_NUL   = 8'h00;

  typedef enum logic [3:0] {
    S_FETCH, S_EXEC, S_WB, S_SKIP_F, S_SKIP_E, S_OUT, S_IN, S_HALT, S_ERR
  } state_t;

  state_t                     state;
  logic [SP_W-1:0]            sp;
  logic [DEP_W-1:0]           depth;
  logic [PROG_ADDR_WIDTH-1:0] stack [STACK_DEPTH];

  logic [PROG_ADDR_WIDTH-1:0] pc_next;
  logic [SP_W-1:0]            sp_m1;
  logic                       cell_nz;
  logic                       sp_full;
  logic                       sp_empty;
  logic                       push;

  assign pc_next  = prog_addr + 1'b1;
  assign sp_m1    = sp - 1'b1;
  assign cell_nz  = |data_rdata;
  assign sp_full  = (sp == SP_W'(STACK_DEPTH));
  assign sp_empty = (sp == '0);
  assign push     = (state == S_EXEC) && (prog_rdata == OP_LB) && cell_nz && !sp_full;

  // Loop stack storage: return address is the opcode just after '['.
  always_ff @(posedge clk) begin
    if (!reset && push) stack[sp[IDX_W-1:0]] <= pc_next;
  end

  // Main sequencer: decode, pointer/cell updates, handshakes, terminal states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      prog_addr  <= '0;
      data_addr  <= '0;
      data_wen   <= 1'b0;
      data_wdata <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      sp         <= '0;
      depth      <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          case (prog_rdata)
            OP_RIGHT: begin data_addr <= data_addr + 1'b1; prog_addr <= pc_next; state <= S_FETCH; end
            OP_LEFT:  begin data_addr <= data_addr - 1'b1; prog_addr <= pc_next; state <= S_FETCH; end
            OP_INC: begin
              data_wdata <= data_rdata + 1'b1; data_wen <= 1'b1;
              prog_addr  <= pc_next; state <= S_WB;
            end
            OP_DEC: begin
              data_wdata <= data_rdata - 1'b1; data_wen <= 1'b1;
              prog_addr  <= pc_next; state <= S_WB;
            end
            OP_OUT: begin
              out_data  <= data_rdata[7:0]; out_valid <= 1'b1;
              prog_addr <= pc_next; state <= S_OUT;
            end
            OP_IN: begin in_ready <= 1'b1; prog_addr <= pc_next; state <= S_IN; end
            OP_LB: begin
              if (cell_nz) begin
                if (sp_full) begin
                  error <= 1'b1; err_code <= 2'd1; state <= S_ERR;
                end else begin
                  sp <= sp + 1'b1; prog_addr <= pc_next; state <= S_FETCH;
                end
              end else begin
                depth <= DEP_W'(1); prog_addr <= pc_next; state <= S_SKIP_F;
              end
            end
            OP_RB: begin
              if (sp_empty) begin
                error <= 1'b1; err_code <= 2'd2; state <= S_ERR;
              end else begin
                // Non-zero cell re-enters the body without popping.
                if (cell_nz) prog_addr <= stack[sp_m1[IDX_W-1:0]];
                else begin sp <= sp_m1; prog_addr <= pc_next; end
                state <= S_FETCH;
              end
            end
            OP_NUL: begin halted <= 1'b1; state <= S_HALT; end
            default: begin prog_addr <= pc_next; state <= S_FETCH; end
          endcase
        end
        S_WB: begin data_wen <= 1'b0; state <= S_FETCH; end
        S_SKIP_F: state <= S_SKIP_E;
        S_SKIP_E: begin
          // Bracket counting only; the loop stack is left alone while skipping.
          if (prog_rdata == OP_NUL) begin
            error <= 1'b1; err_code <= 2'd3; state <= S_ERR;
          end else begin
            prog_addr <= pc_next;
            state     <= S_SKIP_F;
            if (prog_rdata == OP_LB) depth <= depth + 1'b1;
            else if (prog_rdata == OP_RB) begin
              depth <= depth - 1'b1;
              if (depth == DEP_W'(1)) state <= S_FETCH;
            end
          end
        end
        S_OUT: if (out_ready) begin out_valid <= 1'b0; state <= S_FETCH; end
        S_IN: if (in_valid) begin
          data_wdata <= CELL_WIDTH'(in_data); data_wen <= 1'b1;
          in_ready   <= 1'b0; state <= S_WB;
        end
        S_HALT: state <= S_HALT;
        S_ERR:  state <= S_ERR;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_bf_exec_core.sv
// Directed bench for bf_exec_core with behavioural sync program/data RAMs.
module tb_bf_exec_core;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] prog_addr, prog_rdata;
  logic [7:0] data_addr, data_rdata, data_wdata;
  logic       data_wen;
  logic [7:0] out_data, in_data;
  logic       out_valid, out_ready, in_valid, in_ready;
  logic       halted, error;
  logic [1:0] err_code;

  logic [7:0] prog [256];
  logic [7:0] dmem [256];
  logic       clr = 1'b1;
  int         out_cnt;
  logic [7:0] out_last;
  int         checks = 0;
  int         failures = 0;

  bf_exec_core dut (
    .clk(clk), .reset(reset),
    .prog_addr(prog_addr), .prog_rdata(prog_rdata),
    .data_addr(data_addr), .data_rdata(data_rdata),
    .data_wen(data_wen), .data_wdata(data_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .halted(halted), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Program RAM: read-only sync read.
  always @(posedge clk) prog_rdata <= prog[prog_addr];

  // Data RAM: sync read, write on strobe, cleared between tests.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
      data_rdata <= 8'h00;
    end else begin
      if (data_wen) dmem[data_addr] <= data_wdata;
      data_rdata <= dmem[data_addr];
    end
  end

  // Stdout sink capture.
  always @(posedge clk) begin
    if (clr) begin
      out_cnt  <= 0;
      out_last <= 8'h00;
    end else if (out_valid && out_ready) begin
      out_cnt  <= out_cnt + 1;
      out_last <= out_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) prog[i] = s[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clr = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!(halted || error) && n < max) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(halted || error), 32'd1);
  endtask

  task automatic wait_sig(input string tag, input int sel, input int max);
    int n = 0;
    while (!(sel == 0 ? out_valid : in_ready) && n < max) begin @(negedge clk); n++; end
    check({tag, "_seen"}, 32'(sel == 0 ? out_valid : in_ready), 32'd1);
  endtask

  initial begin
    out_ready = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    load("+++.");
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_prog_addr", 32'(prog_addr), 32'd0);
    check("rst_data_addr", 32'(data_addr), 32'd0);
    check("rst_flags", {26'd0, data_wen, out_valid, in_ready, halted, error, 1'b0}, 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    reset = 1'b0; clr = 1'b0;

    wait_done("t1", 200);
    check("t1_out_cnt", 32'(out_cnt), 32'd1);
    check("t1_out", 32'(out_last), 32'h03);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_error", 32'(error), 32'd0);

    load("++[->+<]>.");
    do_reset();
    wait_done("t2", 500);
    check("t2_out", 32'(out_last), 32'h02);
    check("t2_cell0", 32'(dmem[0]), 32'h00);
    check("t2_cell1", 32'(dmem[1]), 32'h02);

    load("[+++]+.");
    do_reset();
    wait_done("t3", 300);
    check("t3_out", 32'(out_last), 32'h01);
    check("t3_error", 32'(error), 32'd0);

    load(",+.");
    do_reset();
    wait_sig("t4_in_ready", 1, 50);
    repeat (5) @(negedge clk);
    check("t4_in_ready_held", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h41;
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_in_ready_drop", 32'(in_ready), 32'd0);
    wait_done("t4", 100);
    check("t4_out", 32'(out_last), 32'h42);

    out_ready = 1'b0;
    load("+.");
    do_reset();
    wait_sig("t5_out_valid", 0, 50);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_valid_held", 32'(out_valid), 32'd1);
      check("t5_data_held", 32'(out_data), 32'h01);
    end
    out_ready = 1'b1;
    wait_done("t5", 100);
    check("t5_out_cnt", 32'(out_cnt), 32'd1);

    load("+[+[+[+[+[+[+[+[+[");
    do_reset();
    wait_done("t6", 500);
    check("t6_error", 32'(error), 32'd1);
    check("t6_code", 32'(err_code), 32'd1);
    check("t6_halted", 32'(halted), 32'd0);

    load("]");
    do_reset();
    wait_done("t7", 100);
    check("t7_code", 32'(err_code), 32'd2);

    load("[");
    do_reset();
    wait_done("t8", 100);
    check("t8_code", 32'(err_code), 32'd3);
    repeat (3) @(negedge clk);
    check("t8_sticky", 32'(error), 32'd1);

    load("-.");
    do_reset();
    wait_done("t9", 100);
    check("t9_out", 32'(out_last), 32'hFF);

    load("<");
    do_reset();
    wait_done("t10", 100);
    check("t10_data_addr", 32'(data_addr), 32'hFF);
    check("t10_halted", 32'(halted), 32'd1);

    out_ready = 1'b0;
    load("+.");
    do_reset();
    wait_sig("t11_out_valid", 0, 50);
    reset = 1'b1; clr = 1'b1;
    @(negedge clk);
    check("t11_valid_rst", 32'(out_valid), 32'd0);
    check("t11_pa_rst", 32'(prog_addr), 32'd0);
    reset = 1'b0; clr = 1'b0; out_ready = 1'b1;
    wait_done("t11", 100);
    check("t11_out", 32'(out_last), 32'h01);
    check("t11_out_cnt", 32'(out_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
